// File: rtl/t05_huffman_decoder.sv
// t05_huffman_decoder
//   Receive side of the t05 Huffman pipeline. Walks the code tree one node at
//   a time, steering left or right with each incoming code bit, and emits a
//   character every time a leaf is reached. Decoding stops after a programmed
//   number of characters.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   1-cycle pulse, honoured in IDLE/ERROR
//   root_index, total_chars tree root and character count, latched on start
//   bit_valid/bit_in/bit_ready          serial code bit stream (0=left, 1=right)
//   node_req/node_addr/node_ack/node_data  node fetch port; data = {left, right},
//                                          child[8]=1 leaf char, 0 internal index
//   char_valid/char_out/char_ready      decoded character stream
//   chars_done              characters accepted by the sink this run
//   busy, done, error       status: running, completion pulse, corrupt tree

module t05_huffman_decoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_DEPTH = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_index,
  input  logic [31:0]       total_chars,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              node_req,
  output logic [ADDR_W-1:0] node_addr,
  input  logic              node_ack,
  input  logic [17:0]       node_data,
  output logic              char_valid,
  output logic [7:0]        char_out,
  input  logic              char_ready,
  output logic [31:0]       chars_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_BIT = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  // The walk is corrupt once an internal node would be entered at this depth.
  localparam logic [6:0] DEPTH_LAST = 7'(MAX_DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] root;
  logic [31:0]       remaining;
  logic [6:0]        depth;
  logic [17:0]       node;
  logic [8:0]        child;

  assign child = bit_in ? node[8:0] : node[17:9];

  always_comb begin
    state_nxt  = state;
    node_req   = 1'b0;
    bit_ready  = 1'b0;
    char_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (total_chars == 32'd0) ? DONE : FETCH;
      end
      FETCH: begin
        node_req = 1'b1;
        if (node_ack) state_nxt = WAIT_BIT;
      end
      WAIT_BIT: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (child[8])                  state_nxt = EMIT;
          else if (depth == DEPTH_LAST)  state_nxt = ERROR;
          else                           state_nxt = FETCH;
        end
      end
      EMIT: begin
        char_valid = 1'b1;
        if (char_ready) state_nxt = (remaining == 32'd1) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nxt = (total_chars == 32'd0) ? DONE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      root       <= '0;
      remaining  <= '0;
      depth      <= '0;
      node       <= '0;
      node_addr  <= '0;
      char_out   <= '0;
      chars_done <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            root       <= root_index;
            remaining  <= total_chars;
            chars_done <= '0;
            depth      <= '0;
            node_addr  <= root_index;
          end
        end
        FETCH: begin
          if (node_ack) node <= node_data;
        end
        WAIT_BIT: begin
          if (bit_valid) begin
            if (child[8]) begin
              char_out <= child[7:0];
              depth    <= '0;
            end else if (depth != DEPTH_LAST) begin
              depth     <= depth + 7'd1;
              node_addr <= child[ADDR_W-1:0];
            end
          end
        end
        EMIT: begin
          // remaining never reaches 0 here: the last char exits to DONE.
          if (char_ready) begin
            chars_done <= chars_done + 32'd1;
            remaining  <= remaining - 32'd1;
            node_addr  <= root;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Testbench for t05_huffman_decoder: directed steps with a character
// scoreboard, a node-memory responder with programmable ack delay and a sink
// with programmable stall.

module tb_t05_huffman_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  root_index;
  logic [31:0] total_chars;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        node_req;
  logic [7:0]  node_addr;
  logic        node_ack;
  logic [17:0] node_data;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        char_ready;
  logic [31:0] chars_done;
  logic        busy;
  logic        done;
  logic        error;

  t05_huffman_decoder #(.ADDR_W(8), .MAX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .root_index(root_index),
    .total_chars(total_chars), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .node_req(node_req), .node_addr(node_addr),
    .node_ack(node_ack), .node_data(node_data), .char_valid(char_valid),
    .char_out(char_out), .char_ready(char_ready), .chars_done(chars_done),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [0:255];
  logic [7:0]  sb[$];
  logic        bq[$];
  int          checks = 0;
  int          passes = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          done_seen = 0;
  int          req_cycles = 0;
  int          addr_moves = 0;
  logic        in_fetch = 1'b0;
  logic [7:0]  fetch_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] leaf(input logic [7:0] c);
    return {1'b1, c};
  endfunction

  function automatic logic [8:0] inode(input logic [7:0] i);
    return {1'b0, i};
  endfunction

  // Called just after a rising edge: present bit, node response and sink ready.
  task automatic drive_inputs();
    bit_valid = (bq.size() != 0);
    bit_in    = (bq.size() != 0) ? bq[0] : 1'b0;
    if (node_req) begin
      node_ack  = (wcnt == ack_delay);
      node_data = mem[node_addr];
      wcnt++;
    end else begin
      node_ack  = 1'b0;
      node_data = '0;
      wcnt      = 0;
    end
    if (char_valid && stall_left > 0) begin
      char_ready = 1'b0;
      stall_left--;
    end else begin
      char_ready = 1'b1;
    end
  endtask

  task automatic tick();
    logic bit_take;
    @(negedge clk);
    chk("exclusive", {31'd0, $onehot0({bit_ready, node_req, char_valid})}, 32'd1);
    if (node_req) begin
      if (!in_fetch) begin
        fetch_addr = node_addr;
        in_fetch   = 1'b1;
      end else if (node_addr !== fetch_addr) begin
        addr_moves++;
      end
      req_cycles++;
    end else begin
      in_fetch = 1'b0;
    end
    if (char_valid && !char_ready) begin
      stall_seen++;
      chk("stall_char", {24'd0, char_out}, {24'd0, (sb.size() != 0) ? sb[0] : 8'hxx});
    end
    if (char_valid && char_ready) begin
      if (sb.size() == 0) chk("char_unexpected", {24'd0, char_out}, 32'hffff_ffff);
      else chk("char", {24'd0, char_out}, {24'd0, sb.pop_front()});
    end
    if (done) done_seen++;
    bit_take = bit_valid && bit_ready;
    @(posedge clk);
    #1;
    if (bit_take) void'(bq.pop_front());
    start = 1'b0;
    drive_inputs();
  endtask

  task automatic pulse_start(input logic [7:0] root, input logic [31:0] total);
    root_index  = root;
    total_chars = total;
    start       = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    done_seen = 0;
    while (done_seen == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_seen, 1);
    tick();
    chk({tag, "_pulse"}, done_seen, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_node_req"},   {31'd0, node_req},   32'd0);
    chk({tag, "_bit_ready"},  {31'd0, bit_ready},  32'd0);
    chk({tag, "_char_valid"}, {31'd0, char_valid}, 32'd0);
    chk({tag, "_char_out"},   {24'd0, char_out},   32'd0);
    chk({tag, "_node_addr"},  {24'd0, node_addr},  32'd0);
    chk({tag, "_chars_done"}, chars_done,          32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_done"},       {31'd0, done},       32'd0);
    chk({tag, "_error"},      {31'd0, error},      32'd0);
  endtask

  task automatic load_abc();
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
    bq.push_back(1'b0);
    bq.push_back(1'b1); bq.push_back(1'b0);
    bq.push_back(1'b1); bq.push_back(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = {leaf(8'h41), inode(8'd1)};
    mem[1] = {leaf(8'h42), leaf(8'h43)};
    rst_n = 1'b0; start = 1'b0; root_index = '0; total_chars = '0;
    bit_valid = 1'b0; bit_in = 1'b0; node_ack = 1'b0; node_data = '0; char_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    drive_inputs();

    // Test 1: A,B,C with zero-wait handshakes, one trailing bit left unread
    load_abc();
    bq.push_back(1'b0);
    pulse_start(8'd0, 32'd3);
    tick();
    chk("t1_req_after_start", {31'd0, node_req}, 32'd1);
    chk("t1_addr_root", {24'd0, node_addr}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    run_until_done("t1_done", 100);
    chk("t1_chars_done", chars_done, 32'd3);
    chk("t1_sb_empty", sb.size(), 0);
    repeat (3) tick();
    chk("t1_bit_ready_after", {31'd0, bit_ready}, 32'd0);
    chk("t1_trailing_bit", bq.size(), 1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    bq.delete();
    drive_inputs();

    // Test 2: zero characters
    pulse_start(8'd0, 32'd0);
    tick();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_no_req", {31'd0, node_req}, 32'd0);
    chk("t2_chars_done", chars_done, 32'd0);
    tick();
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // Test 3: sink stalls 5 cycles on the only character
    sb.push_back(8'h41);
    bq.push_back(1'b0);
    stall_left = 5;
    stall_seen = 0;
    pulse_start(8'd0, 32'd1);
    tick();
    run_until_done("t3_done", 100);
    chk("t3_stall_cycles", stall_seen, 5);
    chk("t3_chars_done", chars_done, 32'd1);

    // Test 4: node ack delayed 3 cycles
    ack_delay = 3;
    req_cycles = 0;
    addr_moves = 0;
    sb.push_back(8'h41);
    bq.push_back(1'b0);
    pulse_start(8'd0, 32'd1);
    tick();
    run_until_done("t4_done", 100);
    chk("t4_req_cycles", req_cycles, 4);
    chk("t4_addr_stable", addr_moves, 0);
    chk("t4_chars_done", chars_done, 32'd1);
    ack_delay = 0;

    // Test 5: corrupt tree loops on node 1 until the depth limit
    mem[1] = {inode(8'd1), inode(8'd1)};
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b0); bq.push_back(1'b0);
    pulse_start(8'd0, 32'd1);
    tick();
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    chk("t5_error", {31'd0, error}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_bits_used", bq.size(), 0);
    repeat (3) tick();
    chk("t5_error_sticky", {31'd0, error}, 32'd1);
    chk("t5_bit_ready", {31'd0, bit_ready}, 32'd0);
    mem[1] = {leaf(8'h42), leaf(8'h43)};
    pulse_start(8'd0, 32'd0);
    tick();
    chk("t5_error_cleared", {31'd0, error}, 32'd0);
    chk("t5_restart_done", {31'd0, done}, 32'd1);
    tick();

    // Test 6: asynchronous reset while a character is pending
    sb.push_back(8'h41); sb.push_back(8'h41);
    bq.push_back(1'b0); bq.push_back(1'b0);
    stall_left = 1000;
    pulse_start(8'd0, 32'd2);
    tick();
    n = 0;
    while (!char_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t6_in_emit", {31'd0, char_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    sb.delete();
    bq.delete();
    stall_left = 0;
    #1 rst_n = 1'b1;
    drive_inputs();
    tick();
    load_abc();
    pulse_start(8'd0, 32'd3);
    tick();
    run_until_done("t6_done", 100);
    chk("t6_chars_done", chars_done, 32'd3);
    chk("t6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
